prog_loader: RTL and testbench

//  Byte-stream program loader: the write side of the core's instruction memory.

---
 rtl/prog_loader.sv | 204 ++++++++++++++++++++
 tb/tb_prog_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed byte stream into instruction memory as little-endian
// 32-bit words, holding the core in reset meanwhile. Define PROG_CHECKSUM_EN for a trailing XOR checksum byte.
module prog_loader #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_DATA, ST_CSUM, ST_FLUSH, ST_DONE, ST_ERR
  } state_t;

  state_t            state_r, state_n;
  logic              s_ready_r, mem_we_r, cpu_hold_r, busy_r, done_r, err_r;
  logic [ADDR_W-1:0] mem_addr_r, word_idx_r;
  logic [31:0]       mem_wdata_r;
  logic [ADDR_W:0]   words_loaded_r;
  logic [23:0]       word_buf_r;
  logic [7:0]        len_r;
  logic [1:0]        byte_idx_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic              hs_s, timeout_s, last_word_s, start_ok_s;

`ifdef PROG_CHECKSUM_EN
  logic [7:0] csum_r;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  assign hs_s        = s_valid & s_ready_r;
  assign timeout_s   = ~hs_s & (to_cnt_r == TO_LAST);
  assign last_word_s = (byte_idx_r == 2'd3) &&
                       ((word_idx_r + ADDR_W'(1'b1)) == ADDR_W'(len_r));
  assign start_ok_s  = (state_r == ST_IDLE) & start;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_n;
  end

  // Next-state logic; a handshake always wins over an expiring timeout
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_n = ST_LEN;
        else       state_n = ST_IDLE;
      end
      ST_LEN: begin
        if (hs_s) begin
          if (s_data == 8'h00) state_n = ST_ERR;
          else                 state_n = ST_DATA;
        end else if (timeout_s) begin
          state_n = ST_ERR;
        end else begin
          state_n = ST_LEN;
        end
      end
      ST_DATA: begin
        if (hs_s && last_word_s) begin
`ifdef PROG_CHECKSUM_EN
          state_n = ST_CSUM;
`else
          state_n = ST_FLUSH;
`endif
        end else if (timeout_s) begin
          state_n = ST_ERR;
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_CSUM: begin
`ifdef PROG_CHECKSUM_EN
        if (hs_s) begin
          if (s_data == csum_r) state_n = ST_DONE;
          else                  state_n = ST_ERR;
        end else if (timeout_s) begin
          state_n = ST_ERR;
        end else begin
          state_n = ST_CSUM;
        end
`else
        state_n = ST_IDLE;
`endif
      end
      ST_FLUSH: state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      ST_ERR:   state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Stall counter: runs only while waiting for bytes, cleared by every handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_r <= '0;
    end else if (hs_s || !(state_r inside {ST_LEN, ST_DATA, ST_CSUM})) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1'b1);
    end
  end

  // Byte packing and memory write port; first byte lands in the LSB
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_r       <= 1'b0;
      mem_addr_r     <= '0;
      mem_wdata_r    <= 32'h0000_0000;
      words_loaded_r <= '0;
      word_buf_r     <= 24'h00_0000;
      len_r          <= 8'h00;
      byte_idx_r     <= 2'd0;
      word_idx_r     <= '0;
    end else begin
      mem_we_r <= 1'b0;
      if (start_ok_s) words_loaded_r <= '0;
      if (hs_s && state_r == ST_LEN) begin
        len_r      <= s_data;
        byte_idx_r <= 2'd0;
        word_idx_r <= '0;
      end
      if (hs_s && state_r == ST_DATA) begin
        word_buf_r <= {s_data, word_buf_r[23:8]};
        byte_idx_r <= byte_idx_r + 2'd1;
        if (byte_idx_r == 2'd3) begin
          mem_we_r       <= 1'b1;
          mem_addr_r     <= word_idx_r;
          mem_wdata_r    <= {s_data, word_buf_r};
          word_idx_r     <= word_idx_r + ADDR_W'(1'b1);
          words_loaded_r <= words_loaded_r + (ADDR_W + 1)'(1'b1);
        end
      end
    end
  end

`ifdef PROG_CHECKSUM_EN
  // Running XOR of the length byte and all data bytes
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_r <= 8'h00;
    end else if (hs_s && state_r == ST_LEN) begin
      csum_r <= s_data;
    end else if (hs_s && state_r == ST_DATA) begin
      csum_r <= csum_fold(csum_r, s_data);
    end
  end
`endif

  // Session status; cpu_hold is only released by a clean finish or reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      cpu_hold_r <= 1'b0;
    end else begin
      s_ready_r <= state_n inside {ST_LEN, ST_DATA, ST_CSUM};
      busy_r    <= state_n inside {ST_LEN, ST_DATA, ST_CSUM, ST_FLUSH};
      if (start_ok_s) begin
        done_r     <= 1'b0;
        err_r      <= 1'b0;
        cpu_hold_r <= 1'b1;
      end else if (state_n == ST_DONE) begin
        done_r     <= 1'b1;
        cpu_hold_r <= 1'b0;
      end else if (state_n == ST_ERR) begin
        err_r <= 1'b1;
      end
    end
  end

  assign s_ready      = s_ready_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign cpu_hold     = cpu_hold_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;
  assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader (short timeout for fast stall tests).
// Honours PROG_CHECKSUM_EN so the same bench covers both builds.
module tb_prog_loader;

  localparam int ADDR_W = 8;
  localparam int TO     = 16;

  logic              clk = 1'b0;
  logic              reset, start, s_valid;
  logic [7:0]        s_data;
  logic              s_ready, mem_we, cpu_hold, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   words_loaded;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  // Record every memory write, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (s_ready === 1'b1) ok = 1'b1;
      tick(1);
    end
    s_valid = 1'b0;
    chk("handshake", {63'd0, ok}, 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 64'd0);
    chk({tag, "_mem_we"}, mem_we, 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_cpu_hold"}, cpu_hold, 64'd0);
    chk({tag, "_busy"}, busy, 64'd0);
    chk({tag, "_done"}, done, 64'd0);
    chk({tag, "_err"}, err, 64'd0);
    chk({tag, "_words"}, words_loaded, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;

    // Reset state
    tick(2);
    chk_all_zero("rst");
    reset = 1'b0;
    tick(1);

    // Basic two-word load, with a start pulse mid-load that must be ignored
    do_start();
    chk("start_busy", busy, 64'd1);
    chk("start_hold", cpu_hold, 64'd1);
    chk("start_ready", s_ready, 64'd1);
    send_byte(8'h02);
    send_byte(8'h78);
    start = 1'b1;
    send_byte(8'h56);
    start = 1'b0;
    send_byte(8'h34);
    send_byte(8'h12);
    chk("w0_we", mem_we, 64'd1);
    chk("w0_addr", mem_addr, 64'd0);
    chk("w0_data", mem_wdata, 64'h1234_5678);
    chk("w0_words", words_loaded, 64'd1);
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    chk("w1_we", mem_we, 64'd1);
    chk("w1_addr", mem_addr, 64'd1);
    chk("w1_data", mem_wdata, 64'hDEAD_BEEF);
    chk("w1_done_early", done, 64'd0);
`ifdef PROG_CHECKSUM_EN
    send_byte(8'h28);
`else
    chk("flush_ready", s_ready, 64'd0);
    tick(1);
`endif
    chk("basic_done", done, 64'd1);
    chk("basic_busy", busy, 64'd0);
    chk("basic_hold", cpu_hold, 64'd0);
    chk("basic_err", err, 64'd0);
    chk("basic_words", words_loaded, 64'd2);
    chk("basic_nwr", wr_addr.size(), 64'd2);
    chk("basic_wr0", wr_data[0], 64'h1234_5678);

    // Bytes after the session are not consumed
    s_valid = 1'b1; s_data = 8'hAA;
    tick(3);
    chk("post_ready", s_ready, 64'd0);
    chk("post_done_held", done, 64'd1);
    s_valid = 1'b0;
    chk("post_nwr", wr_addr.size(), 64'd2);

    // Zero length
    do_start();
    chk("zl_done_clr", done, 64'd0);
    chk("zl_words_clr", words_loaded, 64'd0);
    send_byte(8'h00);
    chk("zl_err", err, 64'd1);
    chk("zl_hold", cpu_hold, 64'd1);
    chk("zl_busy", busy, 64'd0);
    chk("zl_nwr", wr_addr.size(), 64'd2);
    tick(2);

    // New start clears err, hold stays; stall of TO-1 cycles mid-word survives
    do_start();
    chk("rs_err_clr", err, 64'd0);
    chk("rs_hold", cpu_hold, 64'd1);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    tick(TO - 1);
    chk("stall_ok_err", err, 64'd0);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("stall_addr", mem_addr, 64'd0);
    chk("stall_data", mem_wdata, 64'h4433_2211);
`ifdef PROG_CHECKSUM_EN
    send_byte(8'h45);
`else
    tick(1);
`endif
    chk("stall_done", done, 64'd1);
    chk("stall_hold", cpu_hold, 64'd0);
    tick(2);

    // Stall of TO cycles times out; partial word discarded
    do_start();
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    tick(TO);
    chk("to_err", err, 64'd1);
    chk("to_hold", cpu_hold, 64'd1);
    chk("to_busy", busy, 64'd0);
    s_valid = 1'b1; s_data = 8'h33;
    tick(3);
    chk("to_ready", s_ready, 64'd0);
    s_valid = 1'b0;
    tick(2);
    chk("to_nwr", wr_addr.size(), 64'd3);

    // Reset mid-load, then a fresh one-word load
    do_start();
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h05);
    reset = 1'b1;
    tick(1);
    chk_all_zero("midrst");
    reset = 1'b0;
    tick(1);
    do_start();
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("fresh_we", mem_we, 64'd1);
    chk("fresh_addr", mem_addr, 64'd0);
    chk("fresh_data", mem_wdata, 64'h4433_2211);
`ifdef PROG_CHECKSUM_EN
    send_byte(8'h45);
`else
    tick(1);
`endif
    chk("fresh_done", done, 64'd1);
    chk("fresh_words", words_loaded, 64'd1);
    chk("fresh_nwr", wr_addr.size(), 64'd5);

`ifdef PROG_CHECKSUM_EN
    // Bad checksum: writes happen, but the session errors out
    tick(2);
    do_start();
    send_byte(8'h02);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'hEF);
    send_byte(8'hBE);
    send_byte(8'hAD);
    send_byte(8'hDE);
    send_byte(8'h29);
    chk("cs_err", err, 64'd1);
    chk("cs_done", done, 64'd0);
    chk("cs_hold", cpu_hold, 64'd1);
    chk("cs_words", words_loaded, 64'd2);
`endif

    tick(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
